// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite motion controller and the stages around it
// (sprite detection, VGA timing): screen and sprite dimensions, the FSM state
// encoding, and a helper that steps one axis with edge bounce.
// -----------------------------------------------------------------------------
package sprite_pkg;

    // Screen geometry shared with the detection and VGA stages.
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SPRITE_EDGE   = 32;

    // Position registers are 10 bits; arithmetic is done signed in 12 bits
    // so that an overshoot past either edge is visible before clamping.
    localparam int POS_W  = 10;
    localparam int CALC_W = 12;

    // Feedback mask of the 16-bit Galois respawn LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Target life-cycle states; the encoding is visible on the state port.
    typedef enum logic [2:0] {
        ST_FLY     = 3'd0,
        ST_ESCAPE  = 3'd1,
        ST_HIT     = 3'd2,
        ST_FALL    = 3'd3,
        ST_RESPAWN = 3'd4
    } state_e;

    // One axis of motion: position plus direction (neg=1 means moving
    // towards zero).
    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             neg;
    } axis_t;

    // Moves one axis by step in its current direction. Touching or passing
    // an edge pins the position to that edge and turns the direction around,
    // so the sprite never leaves the [0, limit] window.
    function automatic axis_t bounceStep(input logic [POS_W-1:0] pos,
                                         input logic             neg,
                                         input int               step,
                                         input int               limit);
        axis_t                    res;
        logic signed [CALC_W-1:0] cur;
        logic signed [CALC_W-1:0] delta;
        logic signed [CALC_W-1:0] nxt;
        logic signed [CALC_W-1:0] lim;
        cur   = $signed({2'b00, pos});
        delta = CALC_W'(step);
        lim   = CALC_W'(limit);
        nxt   = neg ? (cur - delta) : (cur + delta);
        if (nxt >= lim) begin
            res.pos = lim[POS_W-1:0];
            res.neg = 1'b1;
        end else if (nxt <= 12'sd0) begin
            res.pos = '0;
            res.neg = 1'b0;
        end else begin
            res.pos = nxt[POS_W-1:0];
            res.neg = neg;
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR used to pick respawn positions. It shifts
// right every clock; when the bit shifted out is 1 the tap mask is XORed in.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads SEED
//   lfsr_o  : low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import sprite_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state: right shift, folding the tap mask back in whenever the
    // outgoing bit is set. A non-zero seed keeps it off the all-zero lock-up.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // State register; the seed is reloaded on every reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Drives the position of a 32x32 target sprite through its game life-cycle:
// fly with edge bounce, freeze when hit, fall, stay hidden, respawn at a
// pseudo-random spot, and escape upwards after flying too long. Positions
// only move on the frame-start pulse so the sprite is stable during video.
//   clk            : system/pixel clock
//   reset          : synchronous active-high reset
//   frame_tick     : one-cycle pulse at the start of vertical blank
//   hit            : one-cycle pulse, player shot landed on the sprite
//   sprite_x/_y    : sprite left/top edge for the detection stage
//   sprite_visible : sprite is to be drawn
//   state          : current FSM state (sprite_pkg encoding)
//   score, misses  : hit and escape counters, wrapping at 8 bits
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int          SCREEN_W       = SCREEN_WIDTH,
    parameter int          SCREEN_H       = SCREEN_HEIGHT,
    parameter int          SPRITE_SIZE    = SPRITE_EDGE,
    parameter int          SPEED          = 2,
    parameter int          FALL_SPEED     = 4,
    parameter int          HIT_FRAMES     = 30,
    parameter int          RESPAWN_FRAMES = 60,
    parameter int          FLY_FRAMES     = 600,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       sprite_visible,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [7:0] misses
);

    localparam int          XMAX    = SCREEN_W - SPRITE_SIZE;
    localparam int          YMAX    = SCREEN_H - SPRITE_SIZE;
    localparam logic [9:0]  X_START = 10'(XMAX / 2);
    localparam logic [9:0]  Y_LIMIT = 10'(YMAX);

    state_e      state_q,   state_d;
    logic [9:0]  xPos_q,    xPos_d;
    logic [9:0]  yPos_q,    yPos_d;
    logic        dxNeg_q,   dxNeg_d;
    logic        dyNeg_q,   dyNeg_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [7:0]  score_q,   score_d;
    logic [7:0]  misses_q,  misses_d;
    logic        visible_q, visible_d;

    logic [9:0]               lfsrVal;
    axis_t                    xStep;
    axis_t                    yStep;
    logic signed [CALC_W-1:0] yEsc;
    logic signed [CALC_W-1:0] yFall;
    logic [9:0]               yEscPos;
    logic [9:0]               yFallPos;
    logic [15:0]              cntInc;

    // Only the low ten bits feed the respawn position and direction.
    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (10)
    ) uLfsr (
        .clk_i   (clk),
        .reset_i (reset),
        .lfsr_o  (lfsrVal)
    );

    // Next-state and datapath. Candidate moves are computed up front for
    // every mode, then the state case picks which ones to commit. A hit in
    // FLY or ESCAPE takes priority over a frame tick in the same cycle, so
    // the sprite freezes exactly where it was shot.
    always_comb begin
        state_d   = state_q;
        xPos_d    = xPos_q;
        yPos_d    = yPos_q;
        dxNeg_d   = dxNeg_q;
        dyNeg_d   = dyNeg_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        misses_d  = misses_q;

        cntInc   = cnt_q + 16'd1;
        xStep    = bounceStep(xPos_q, dxNeg_q, SPEED, XMAX);
        yStep    = bounceStep(yPos_q, dyNeg_q, SPEED, YMAX);
        yEsc     = $signed({2'b00, yPos_q}) - CALC_W'(SPEED);
        yFall    = $signed({2'b00, yPos_q}) + CALC_W'(FALL_SPEED);
        yEscPos  = (yEsc <= 12'sd0) ? 10'd0 : yEsc[9:0];
        yFallPos = (yFall >= CALC_W'(YMAX)) ? Y_LIMIT : yFall[9:0];

        case (state_q)
            ST_FLY, ST_ESCAPE: begin
                if (hit) begin
                    state_d = ST_HIT;
                    score_d = score_q + 8'd1;
                    cnt_d   = '0;
                end else if (frame_tick) begin
                    xPos_d  = xStep.pos;
                    dxNeg_d = xStep.neg;
                    if (state_q == ST_FLY) begin
                        yPos_d  = yStep.pos;
                        dyNeg_d = yStep.neg;
                        if (cntInc == 16'(FLY_FRAMES)) begin
                            state_d = ST_ESCAPE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        yPos_d = yEscPos;
                        if (yEscPos == 10'd0) begin
                            state_d  = ST_RESPAWN;
                            misses_d = misses_q + 8'd1;
                            cnt_d    = '0;
                        end
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (cntInc == 16'(HIT_FRAMES)) begin
                        state_d = ST_FALL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
            end
            ST_FALL: begin
                if (frame_tick) begin
                    yPos_d = yFallPos;
                    if (yFallPos == Y_LIMIT) begin
                        state_d = ST_RESPAWN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RESPAWN: begin
                // x = {0, lfsr[8:0]} tops out at 511, which is always
                // inside the screen, so no clamp is needed here.
                if (frame_tick) begin
                    if (cntInc == 16'(RESPAWN_FRAMES)) begin
                        state_d = ST_FLY;
                        xPos_d  = {1'b0, lfsrVal[8:0]};
                        yPos_d  = Y_LIMIT;
                        dxNeg_d = lfsrVal[9];
                        dyNeg_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
            end
            default: begin
                state_d = ST_FLY;
                cnt_d   = '0;
            end
        endcase

        visible_d = (state_d != ST_RESPAWN);
    end

    // State and datapath registers. Reset parks the sprite mid-screen on
    // the bottom edge heading up-right, whatever it was doing before.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FLY;
            xPos_q    <= X_START;
            yPos_q    <= Y_LIMIT;
            dxNeg_q   <= 1'b0;
            dyNeg_q   <= 1'b1;
            cnt_q     <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            visible_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            xPos_q    <= xPos_d;
            yPos_q    <= yPos_d;
            dxNeg_q   <= dxNeg_d;
            dyNeg_q   <= dyNeg_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            visible_q <= visible_d;
        end
    end

    assign sprite_x       = xPos_q;
    assign sprite_y       = yPos_q;
    assign sprite_visible = visible_q;
    assign state          = state_q;
    assign score          = score_q;
    assign misses         = misses_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Two controllers share one stimulus stream: dutA with the normal flight time
// and dutB with a four-frame flight so the escape path is reached quickly.
// A behavioural model of the game rules runs beside each one and is compared
// every cycle; literal checks pin the model to hand-worked trajectories.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        int x;
        int y;
        int dx;
        int dy;
        int st;
        int cnt;
        int score;
        int misses;
    } mdl_t;

    logic clk;
    logic reset;
    logic frame_tick;
    logic hit;

    logic [9:0] xA, yA, xB, yB;
    logic       visA, visB;
    logic [2:0] stA, stB;
    logic [7:0] scA, scB, miA, miB;

    int vectors;
    int miscompares;

    mdl_t        mA;
    mdl_t        mB;
    logic [15:0] lfsrM;
    logic [15:0] lfsrAtTick;
    bit          modelValid;
    int          respawnX;

    sprite_motion_ctrl dutA (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .hit            (hit),
        .sprite_x       (xA),
        .sprite_y       (yA),
        .sprite_visible (visA),
        .state          (stA),
        .score          (scA),
        .misses         (miA)
    );

    sprite_motion_ctrl #(.FLY_FRAMES(4)) dutB (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .hit            (hit),
        .sprite_x       (xB),
        .sprite_y       (yB),
        .sprite_visible (visB),
        .state          (stB),
        .score          (scB),
        .misses         (miB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t resetModel();
        mdl_t m;
        m.x = 304; m.y = 448; m.dx = 1; m.dy = -1;
        m.st = 0; m.cnt = 0; m.score = 0; m.misses = 0;
        return m;
    endfunction

    // One clock of the game rules: 0=FLY 1=ESCAPE 2=HIT 3=FALL 4=RESPAWN.
    function automatic mdl_t modelStep(mdl_t mi, bit tick, bit h,
                                       logic [15:0] lfsr, int flyFrames);
        mdl_t m;
        int nx;
        int ny;
        m = mi;
        if (h && (m.st == 0 || m.st == 1)) begin
            m.st = 2;
            m.score = (m.score + 1) % 256;
            m.cnt = 0;
            return m;
        end
        if (!tick) return m;
        case (m.st)
            0, 1: begin
                nx = m.x + m.dx * 2;
                if (nx >= 608) begin m.x = 608; m.dx = -1; end
                else if (nx <= 0) begin m.x = 0; m.dx = 1; end
                else m.x = nx;
                if (m.st == 0) begin
                    ny = m.y + m.dy * 2;
                    if (ny >= 448) begin m.y = 448; m.dy = -1; end
                    else if (ny <= 0) begin m.y = 0; m.dy = 1; end
                    else m.y = ny;
                    m.cnt++;
                    if (m.cnt == flyFrames) begin m.st = 1; m.cnt = 0; end
                end else begin
                    m.y = (m.y - 2 < 0) ? 0 : m.y - 2;
                    if (m.y == 0) begin
                        m.misses = (m.misses + 1) % 256;
                        m.st = 4;
                        m.cnt = 0;
                    end
                end
            end
            2: begin
                m.cnt++;
                if (m.cnt == 30) begin m.st = 3; m.cnt = 0; end
            end
            3: begin
                m.y = (m.y + 4 > 448) ? 448 : m.y + 4;
                if (m.y == 448) begin m.st = 4; m.cnt = 0; end
            end
            default: begin
                m.cnt++;
                if (m.cnt == 60) begin
                    m.st = 0;
                    m.x = int'(lfsr[8:0]);
                    m.y = 448;
                    m.dx = lfsr[9] ? -1 : 1;
                    m.dy = -1;
                    m.cnt = 0;
                end
            end
        endcase
        return m;
    endfunction

    // Advance both models and the reference LFSR on every rising edge using
    // the same inputs the DUTs sample there.
    always @(posedge clk) begin
        if (reset) begin
            mA = resetModel();
            mB = resetModel();
            lfsrM = SEED;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (frame_tick) lfsrAtTick = lfsrM;
            mA = modelStep(mA, frame_tick, hit, lfsrM, 600);
            mB = modelStep(mB, frame_tick, hit, lfsrM, 4);
            lfsrM = (lfsrM >> 1) ^ (lfsrM[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic compareModel(input string tag, input logic [9:0] x,
                                input logic [9:0] y, input logic vis,
                                input logic [2:0] st, input logic [7:0] sc,
                                input logic [7:0] mi, input mdl_t m);
        vectors++;
        if (x !== 10'(m.x) || y !== 10'(m.y) || vis !== (m.st != 4) ||
            st !== 3'(m.st) || sc !== 8'(m.score) || mi !== 8'(m.misses)) begin
            miscompares++;
            $display("[TB] FAIL model_%s t=%0t got x=%0d y=%0d vis=%0b st=%0d sc=%0d mi=%0d expected x=%0d y=%0d vis=%0b st=%0d sc=%0d mi=%0d",
                     tag, $time, x, y, vis, st, sc, mi,
                     m.x, m.y, (m.st != 4), m.st, m.score, m.misses);
        end
    endtask

    // Every falling edge the registered outputs are settled; check them.
    always @(negedge clk) begin
        if (modelValid) begin
            compareModel("A", xA, yA, visA, stA, scA, miA, mA);
            compareModel("B", xB, yB, visB, stB, scB, miB, mB);
        end
    end

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called at a falling edge: holds the inputs for one rising edge, then
    // idles for the requested number of cycles.
    task automatic applyStimulus(input bit tick, input bit h, input bit rst,
                                 input int idle);
        frame_tick = tick;
        hit        = h;
        reset      = rst;
        @(negedge clk);
        frame_tick = 1'b0;
        hit        = 1'b0;
        reset      = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_x"}, int'(xA), 304);
        checkOutput({tag, "_y"}, int'(yA), 448);
        checkOutput({tag, "_vis"}, int'(visA), 1);
        checkOutput({tag, "_state"}, int'(stA), 0);
        checkOutput({tag, "_score"}, int'(scA), 0);
        checkOutput({tag, "_misses"}, int'(miA), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelValid  = 1'b0;
        frame_tick  = 1'b0;
        hit         = 1'b0;
        reset       = 1'b0;
        @(negedge clk);

        // Reset values, then straight-line flight up and to the right.
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        checkResetState("reset");
        ticks(4);
        checkOutput("B_escape_state", int'(stB), 1);
        checkOutput("B_escape_y", int'(yB), 440);
        ticks(6);
        checkOutput("fly10_x", int'(xA), 324);
        checkOutput("fly10_y", int'(yA), 428);
        checkOutput("fly10_state", int'(stA), 0);
        checkOutput("fly10_vis", int'(visA), 1);
        checkOutput("fly10_score", int'(scA), 0);

        // Right-edge bounce, then top-edge bounce.
        ticks(142);
        checkOutput("t152_x", int'(xA), 608);
        checkOutput("t152_y", int'(yA), 144);
        ticks(1);
        checkOutput("t153_x", int'(xA), 606);
        ticks(71);
        checkOutput("t224_y", int'(yA), 0);
        checkOutput("B_miss_misses", int'(miB), 1);
        checkOutput("B_miss_state", int'(stB), 4);
        checkOutput("B_miss_vis", int'(visB), 0);
        checkOutput("B_miss_score", int'(scB), 0);
        ticks(1);
        checkOutput("t225_y", int'(yA), 2);

        // Hit, freeze, fall, respawn; hits outside FLY/ESCAPE are ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        ticks(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("hit_state", int'(stA), 2);
        checkOutput("hit_score", int'(scA), 1);
        checkOutput("hit_x", int'(xA), 314);
        checkOutput("hit_y", int'(yA), 438);
        ticks(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("hit_in_hit_score", int'(scA), 1);
        ticks(19);
        checkOutput("hold29_state", int'(stA), 2);
        checkOutput("hold29_y", int'(yA), 438);
        ticks(1);
        checkOutput("fall_state", int'(stA), 3);
        checkOutput("fall_y0", int'(yA), 438);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("hit_in_fall_score", int'(scA), 1);
        ticks(1);
        checkOutput("fall_y1", int'(yA), 442);
        ticks(1);
        checkOutput("fall_y2", int'(yA), 446);
        ticks(1);
        checkOutput("fall_y3", int'(yA), 448);
        checkOutput("respawn_state", int'(stA), 4);
        checkOutput("respawn_vis", int'(visA), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("hit_in_respawn_score", int'(scA), 1);
        ticks(59);
        checkOutput("respawn59_state", int'(stA), 4);
        ticks(1);
        respawnX = int'(lfsrAtTick[8:0]);
        checkOutput("respawn_fly_state", int'(stA), 0);
        checkOutput("respawn_fly_vis", int'(visA), 1);
        checkOutput("respawn_fly_y", int'(yA), 448);
        checkOutput("respawn_fly_x", int'(xA), respawnX);

        // Hit and frame tick together: the hit wins, nothing moves.
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("coinc_state", int'(stA), 2);
        checkOutput("coinc_x", int'(xA), respawnX);
        checkOutput("coinc_y", int'(yA), 448);
        checkOutput("coinc_score", int'(scA), 2);

        // Reset in the middle of a fall, then normal flight again.
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        ticks(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        ticks(30);
        checkOutput("midfall_state", int'(stA), 3);
        ticks(1);
        checkOutput("midfall_y", int'(yA), 442);
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        checkResetState("midfall_reset");
        ticks(3);
        checkOutput("after_reset_x", int'(xA), 310);
        checkOutput("after_reset_y", int'(yA), 442);
        checkOutput("after_reset_state", int'(stA), 0);

        // Random traffic, judged by the models alone.
        for (int i = 0; i < 6000; i++) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          $urandom_range(0, 79) == 0,
                          $urandom_range(0, 1999) == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
